// File: rtl/ysyx_23060208_mem_arbiter_pkg.sv
// Shared definitions for the two-master / one-slave AXI-lite memory arbiter.
// - arb_state_e : FSM state encoding. The encoding doubles as the debug
//                 grant value (00 idle, 01 m0 read, 10 m1 read, 11 m1 write).
// - RESP_*      : AXI-lite response codes. They are passed through untouched.
package ysyx_23060208_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD0  = 2'd1,
        ARB_RD1  = 2'd2,
        ARB_WR   = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_23060208_mem_arbiter_if.sv
// AXI-lite bus bundle used on every side of the memory arbiter.
// Channels carried: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready).
// - master modport: the side that issues requests (drives valids and payload).
// - slave modport : the side that answers (drives readys and responses).
// wstrb uses the core encoding (100 word, 010 half, 001 byte).
interface ysyx_23060208_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 3
);
    logic [DATA_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [DATA_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/ysyx_23060208_mem_arbiter_arb_pick.sv
// Combinational request selector for the memory arbiter.
// Ports:
//   wr_req     in  : m1 write address valid (always highest priority)
//   rd1_req    in  : m1 read address valid
//   rd0_req    in  : m0 (IFU) read address valid
//   last_rd    in  : last granted reader (0 = m0, 1 = m1); only meaningful
//                    when ARB_RR_EN is defined
//   next_state out : state to enter from IDLE (ARB_IDLE when nothing pending)
// Build option: ARB_RR_EN selects round-robin between the two readers;
// otherwise m1 reads beat m0 reads.
module ysyx_23060208_arb_pick
    import ysyx_23060208_mem_arbiter_pkg::*;
(
    input  logic       wr_req,
    input  logic       rd1_req,
    input  logic       rd0_req,
    input  logic       last_rd,
    output arb_state_e next_state
);

`ifndef ARB_RR_EN
    // Fixed priority ignores the reader history.
    logic unused_last_rd;
    assign unused_last_rd = last_rd;
`endif

    always_comb begin
        next_state = ARB_IDLE;
        if (wr_req) begin
            next_state = ARB_WR;
        end else if (rd1_req && rd0_req) begin
`ifdef ARB_RR_EN
            // Contention goes to whichever reader was not served last.
            next_state = last_rd ? ARB_RD0 : ARB_RD1;
`else
            next_state = ARB_RD1;
`endif
        end else if (rd1_req) begin
            next_state = ARB_RD1;
        end else if (rd0_req) begin
            next_state = ARB_RD0;
        end
    end

endmodule

// File: rtl/ysyx_23060208_mem_arbiter.sv
// Two-master, one-slave AXI-lite arbiter between the core and data memory.
// m0 is the IFU fetch port (read only), m1 is the EXU load/store port.
// All traffic is serialized onto the slave port with a single outstanding
// transaction; arbitration happens only in IDLE and the winner is registered,
// so the slave sees a request one cycle after the master raises valid.
// Ports:
//   clk   in  : clock
//   rst   in  : synchronous, active-low reset
//   m0    slave modport  : IFU bus (only AR/R used; AW/W/B tied off)
//   m1    slave modport  : EXU bus (AW/W/B/AR/R)
//   s     master modport : memory-side bus
//   grant out : debug, 00 idle, 01 m0 read, 10 m1 read, 11 m1 write
// Build option: ARB_RR_EN enables round-robin between m0 and m1 reads
// (a pending m1 write still wins).
module ysyx_23060208_mem_arbiter
    import ysyx_23060208_mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    ysyx_23060208_mem_arbiter_if.slave         m0,
    ysyx_23060208_mem_arbiter_if.slave         m1,
    ysyx_23060208_mem_arbiter_if.master        s,
    output logic [1:0]                         grant
);

    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;
    localparam logic [STRB_WIDTH-1:0] STRB_ZERO = '0;

    arb_state_e state_q, state_d, pick_state;
    logic       aw_done_q, w_done_q;
    logic       aw_hs, w_hs, wr_exit;
    logic       last_rd;

    // m0 never writes: its write channels are tied off and its inputs sunk.
    logic unused_m0_wr;
    assign unused_m0_wr = ^{m0.awaddr, m0.awvalid, m0.wdata, m0.wstrb, m0.wvalid, m0.bready};
    assign m0.awready = 1'b0;
    assign m0.wready  = 1'b0;
    assign m0.bvalid  = 1'b0;
    assign m0.bresp   = RESP_OKAY;

`ifdef ARB_RR_EN
    logic last_rd_q;
    assign last_rd = last_rd_q;
`else
    assign last_rd = 1'b0;
`endif

    ysyx_23060208_arb_pick u_pick (
        .wr_req     (m1.awvalid),
        .rd1_req    (m1.arvalid),
        .rd0_req    (m0.arvalid),
        .last_rd    (last_rd),
        .next_state (pick_state)
    );

    // Handshakes as seen on the slave side; a channel whose flag is already
    // set no longer presents valid, so it cannot handshake twice.
    assign aw_hs   = (state_q == ARB_WR) && m1.awvalid && !aw_done_q && s.awready;
    assign w_hs    = (state_q == ARB_WR) && m1.wvalid  && !w_done_q  && s.wready;
    assign wr_exit = (state_q == ARB_WR) && aw_done_q && w_done_q && s.bvalid && m1.bready;

    assign grant = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ARB_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef ARB_RR_EN
            last_rd_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (wr_exit) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
`ifdef ARB_RR_EN
            if (state_q == ARB_IDLE) begin
                if (state_d == ARB_RD0)      last_rd_q <= 1'b0;
                else if (state_d == ARB_RD1) last_rd_q <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_d    = state_q;

        s.awaddr   = DATA_ZERO;
        s.awvalid  = 1'b0;
        s.wdata    = DATA_ZERO;
        s.wstrb    = STRB_ZERO;
        s.wvalid   = 1'b0;
        s.bready   = 1'b0;
        s.araddr   = DATA_ZERO;
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;

        m0.arready = 1'b0;
        m0.rdata   = DATA_ZERO;
        m0.rresp   = RESP_OKAY;
        m0.rvalid  = 1'b0;

        m1.awready = 1'b0;
        m1.wready  = 1'b0;
        m1.bresp   = RESP_OKAY;
        m1.bvalid  = 1'b0;
        m1.arready = 1'b0;
        m1.rdata   = DATA_ZERO;
        m1.rresp   = RESP_OKAY;
        m1.rvalid  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                state_d = pick_state;
            end
            ARB_RD0: begin
                s.araddr   = m0.araddr;
                s.arvalid  = m0.arvalid;
                m0.arready = s.arready;
                m0.rdata   = s.rdata;
                m0.rresp   = s.rresp;
                m0.rvalid  = s.rvalid;
                s.rready   = m0.rready;
                if (s.rvalid && m0.rready) state_d = ARB_IDLE;
            end
            ARB_RD1: begin
                s.araddr   = m1.araddr;
                s.arvalid  = m1.arvalid;
                m1.arready = s.arready;
                m1.rdata   = s.rdata;
                m1.rresp   = s.rresp;
                m1.rvalid  = s.rvalid;
                s.rready   = m1.rready;
                if (s.rvalid && m1.rready) state_d = ARB_IDLE;
            end
            ARB_WR: begin
                s.awaddr   = m1.awaddr;
                s.awvalid  = m1.awvalid && !aw_done_q;
                m1.awready = s.awready && !aw_done_q;
                s.wdata    = m1.wdata;
                s.wstrb    = m1.wstrb;
                s.wvalid   = m1.wvalid && !w_done_q;
                m1.wready  = s.wready && !w_done_q;
                // The response is only meaningful once both halves landed.
                if (aw_done_q && w_done_q) begin
                    m1.bresp  = s.bresp;
                    m1.bvalid = s.bvalid;
                    s.bready  = m1.bready;
                end
                if (wr_exit) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule
